// File: rtl/riscv_dmem_ctrl.sv
// Data-memory sequencer between MEM/WB and a req/gnt/rvalid bus.
// Checks alignment and page faults up front, and times out on a missing response.
module riscv_dmem_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_adr_i,
  input  logic [2:0]        mem_size_i,
  input  logic [XLEN-1:0]   mem_d_i,
  input  logic              mem_flush_i,
  input  logic              pf_i,
  output logic              dmem_ack_o,
  output logic              dmem_err_o,
  output logic              dmem_misaligned_o,
  output logic              dmem_page_fault_o,
  output logic [XLEN-1:0]   dmem_q_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_adr_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic              bus_err_i,
  input  logic [XLEN-1:0]   bus_q_i
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = (XLEN == 64) ? 3 : 2;
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

  function automatic logic [BE_W-1:0] lane_mask(input logic [2:0] size,
                                                 input logic [OFF_W-1:0] off);
    logic [BE_W-1:0] m;
    case (size[1:0])
      2'd0:    m = BE_W'(8'h01);
      2'd1:    m = BE_W'(8'h03);
      2'd2:    m = BE_W'(8'h0F);
      default: m = BE_W'(8'hFF);
    endcase
    return m << off;
  endfunction

  // Size 7 is not a valid func3 width, and doubleword needs a 64-bit bus.
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] low;
    case (size[1:0])
      2'd0:    low = '0;
      2'd1:    low = OFF_W'(1);
      2'd2:    low = OFF_W'(3);
      default: low = OFF_W'(7);
    endcase
    return (size == 3'd7) || ((size[1:0] == 2'd3) && (XLEN == 32)) ||
           ((off & low) != '0);
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              timeout_hit;
  logic [OFF_W-1:0]  off;
  logic              req_nxt, we_nxt;
  logic [XLEN-1:0]   adr_nxt, d_nxt, q_nxt;
  logic [BE_W-1:0]   be_nxt;
  logic              ack_nxt, err_nxt, mis_nxt, pf_nxt;

  assign off         = mem_adr_i[OFF_W-1:0];
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = bus_req_o;
    we_nxt    = bus_we_o;
    adr_nxt   = bus_adr_o;
    be_nxt    = bus_be_o;
    d_nxt     = bus_d_o;
    q_nxt     = dmem_q_o;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    mis_nxt   = 1'b0;
    pf_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i && !mem_flush_i) begin
          if (is_misaligned(mem_size_i, off)) begin
            state_nxt = RESP;
            mis_nxt   = 1'b1;
          end else if (pf_i) begin
            state_nxt = RESP;
            pf_nxt    = 1'b1;
          end else begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
            we_nxt    = mem_we_i;
            adr_nxt   = {mem_adr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            be_nxt    = lane_mask(mem_size_i, off);
            d_nxt     = mem_d_i << {off, 3'b000};
          end
        end
      end
      REQ: begin
        // Once granted the bus owes a response, so a coincident flush must drain it.
        if (bus_gnt_i) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = mem_flush_i ? DRAIN : WAIT;
        end else if (mem_flush_i) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt_inc;
        if (mem_flush_i) begin
          state_nxt = (bus_rvalid_i || bus_err_i || timeout_hit) ? IDLE : DRAIN;
        end else if (bus_err_i) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end else if (bus_rvalid_i) begin
          state_nxt = RESP;
          ack_nxt   = 1'b1;
          q_nxt     = bus_q_i;
        end else if (timeout_hit) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt_inc;
        if (bus_rvalid_i || bus_err_i || timeout_hit) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      cnt               <= '0;
      bus_req_o         <= 1'b0;
      bus_we_o          <= 1'b0;
      bus_adr_o         <= '0;
      bus_be_o          <= '0;
      bus_d_o           <= '0;
      dmem_q_o          <= '0;
      dmem_ack_o        <= 1'b0;
      dmem_err_o        <= 1'b0;
      dmem_misaligned_o <= 1'b0;
      dmem_page_fault_o <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      bus_req_o         <= req_nxt;
      bus_we_o          <= we_nxt;
      bus_adr_o         <= adr_nxt;
      bus_be_o          <= be_nxt;
      bus_d_o           <= d_nxt;
      dmem_q_o          <= q_nxt;
      dmem_ack_o        <= ack_nxt;
      dmem_err_o        <= err_nxt;
      dmem_misaligned_o <= mis_nxt;
      dmem_page_fault_o <= pf_nxt;
    end
  end

endmodule
